tx_fir_sequencer: RTL and testbench
===================================

TX_FIR_SEQUENCER -- requirements
Module: tx_fir_sequencer

Interface
REQ-001 SHALL have parameter NB_OUTPUT, default 8, width of the captured FIR sample.
REQ-002 SHALL have parameter NB_DIV, default 8, width of the sample-rate divider.
REQ-003 SHALL have parameter NBAUDS, default 6, filter length in symbols (priming count).
REQ-004 SHALL have port clock  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_enable  input  1  run request; high = start or continue, low = stop.
REQ-007 SHALL have port i_div  input  NB_DIV  clocks per output sample minus one.
REQ-008 SHALL have port i_fir_sample  input  NB_OUTPUT (signed)  combinational FIR output for the current o_phase.
REQ-009 SHALL have port i_ready  input  1  downstream accepts o_sample.
REQ-010 SHALL have port o_phase  output  2  polyphase selector to the FIR coefficient mux.
REQ-011 SHALL have port o_shift  output  1  one-clock pulse that advances the FIR symbol register and the PRBS.
REQ-012 SHALL have port o_fir_enable  output  1  FIR enable; high in every state except IDLE.
REQ-013 SHALL have port o_sample  output  NB_OUTPUT (signed)  held output sample.
REQ-014 SHALL have port o_valid  output  1  o_sample holds an unconsumed sample.
REQ-015 SHALL have port o_overrun  output  1  sticky flag; a sample was dropped.
REQ-016 SHALL have port o_state  output  2  state code: IDLE=0, PRIME=1, RUN=2, STOP=3.

Function
REQ-017 SHALL latch i_div into div_q on the IDLE->PRIME transition only; i_div changes at any other time have no effect.
REQ-018 SHALL run a prescaler that counts 0..div_q outside IDLE and generates tick when count==div_q, then wraps to 0. div_q=0 gives a tick every clock.
REQ-019 SHALL hold the prescaler and o_phase at 0 in IDLE.
REQ-020 SHALL increment o_phase modulo 4 on every tick.
REQ-021 SHALL drive o_shift = tick AND o_phase==1, from registered state, so the FIR shift register updates on the same edge as the 1->2 phase step.
REQ-022 SHALL transition IDLE->PRIME when i_enable=1.
REQ-023 SHALL count o_shift pulses in PRIME and transition PRIME->RUN on the edge of the NBAUDS-th pulse; PRIME SHALL NOT capture samples.
REQ-024 SHALL capture i_fir_sample into o_sample and set o_valid on the edge of every tick in RUN; o_valid is seen one clock after the tick cycle.
REQ-025 SHALL clear o_valid on the edge where o_valid=1 and i_ready=1, unless a capture occurs on the same edge, in which case it SHALL load the new sample and keep o_valid=1.
REQ-026 SHALL drop the new sample when a tick occurs while o_valid=1 and i_ready=0, keep the old o_sample, and set o_overrun; o_overrun clears only on reset.
REQ-027 SHALL transition RUN->STOP when i_enable=0; STOP SHALL continue ticking and capturing until the tick with o_phase==3, then go to IDLE on that edge, so the last symbol emits all 4 phases.
REQ-028 SHALL transition PRIME->IDLE directly, with no captures, when i_enable=0 in PRIME.
REQ-029 SHALL go from STOP back to RUN, with no re-prime, when i_enable returns to 1 in STOP.
REQ-030 SHALL keep o_valid and o_sample through STOP->IDLE until the sample is consumed.

Reset
REQ-031 SHALL, while i_reset=1, set the state to IDLE and set o_phase=0, o_shift=0, o_fir_enable=0, o_sample=0, o_valid=0, o_overrun=0, prescaler=0, prime count=0, div_q=0; reset SHALL take priority over every other event, including mid-run.

Verification
REQ-032 SHALL cover: i_div=0, i_enable=1, i_ready=1 -> PRIME lasts 6 shifts; first o_valid 24 clocks after start; then o_valid every clock; o_phase sequence 0,1,2,3.
REQ-033 SHALL cover: i_div=3 -> tick every 4 clocks; o_shift every 16 clocks; changing i_div to 0 mid-RUN leaves the period at 4.
REQ-034 SHALL cover: i_ready=0 held across two RUN ticks -> first sample held, second dropped, o_overrun=1 and it stays 1 after i_ready=1.
REQ-035 SHALL cover: i_enable dropped at o_phase=1 in RUN -> captures at phases 1,2,3 continue, then IDLE, o_phase=0, o_fir_enable=0.
REQ-036 SHALL cover: i_reset pulsed mid-RUN with o_valid=1 -> next clock all outputs 0, state IDLE; i_enable=1 restarts with a full prime.
REQ-037 SHALL cover: simultaneous tick and i_ready=1 with o_valid=1 -> new sample loaded, o_valid stays 1, no overrun.

Source files
------------

// File: rtl/tx_fir_sequencer.sv
// Polyphase FIR sequencer: sample-rate prescaler, 4-phase selector, FIR priming
// and a one-deep held output sample with sticky overrun.
module tx_fir_sequencer #(
  parameter int NB_OUTPUT = 8,
  parameter int NB_DIV    = 8,
  parameter int NBAUDS    = 6
) (
  input  logic                        clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic [NB_DIV-1:0]           i_div,
  input  logic signed [NB_OUTPUT-1:0] i_fir_sample,
  input  logic                        i_ready,
  output logic [1:0]                  o_phase,
  output logic                        o_shift,
  output logic                        o_fir_enable,
  output logic signed [NB_OUTPUT-1:0] o_sample,
  output logic                        o_valid,
  output logic                        o_overrun,
  output logic [1:0]                  o_state
);

  localparam int NB_PRIME = $clog2(NBAUDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [NB_DIV-1:0]             div_q, div_d;
  logic [NB_DIV-1:0]             presc_q, presc_d;
  logic [1:0]                    phase_q, phase_d;
  logic [NB_PRIME-1:0]           prime_q, prime_d;
  logic signed [NB_OUTPUT-1:0]   sample_q, sample_d;
  logic                          valid_q, valid_d;
  logic                          overrun_q, overrun_d;
  logic                          tick;
  logic                          shift;
  logic                          capture;

  assign tick  = (state_q != IDLE) && (presc_q == div_q);
  assign shift = tick && (phase_q == 2'd1);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      presc_q   <= '0;
      phase_q   <= '0;
      prime_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      prime_q   <= prime_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    presc_d   = presc_q;
    phase_d   = phase_q;
    prime_d   = prime_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    capture   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d = PRIME;
          div_d   = i_div;
          prime_d = '0;
        end
      end
      PRIME: begin
        if (!i_enable) begin
          state_d = IDLE;
        end else if (shift) begin
          if (prime_q == NB_PRIME'(NBAUDS - 1)) begin
            state_d = RUN;
            prime_d = '0;
          end else begin
            prime_d = prime_q + 1'b1;
          end
        end
      end
      RUN: begin
        capture = tick;
        if (!i_enable) state_d = STOP;
      end
      STOP: begin
        capture = tick;
        if (i_enable) begin
          state_d = RUN;
        end else if (tick && (phase_q == 2'd3)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) phase_d = phase_q + 2'd1;
    end
    // Any entry into IDLE (PRIME abort included) parks the prescaler and phase.
    if (state_d == IDLE) begin
      presc_d = '0;
      phase_d = '0;
    end

    if (capture) begin
      if (!valid_q || i_ready) begin
        sample_d = i_fir_sample;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  assign o_phase      = phase_q;
  assign o_shift      = shift;
  assign o_fir_enable = (state_q != IDLE);
  assign o_sample     = sample_q;
  assign o_valid      = valid_q;
  assign o_overrun    = overrun_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_tx_fir_sequencer.sv
// Directed bench for tx_fir_sequencer: a per-step vector table for a full
// div=0 run, plus hand sequences for prescaler, overrun, abort and reset.
module tb_tx_fir_sequencer;

  logic              clock;
  logic              i_reset;
  logic              i_enable;
  logic [7:0]        i_div;
  logic signed [7:0] i_fir_sample;
  logic              i_ready;
  logic [1:0]        o_phase;
  logic              o_shift;
  logic              o_fir_enable;
  logic signed [7:0] o_sample;
  logic              o_valid;
  logic              o_overrun;
  logic [1:0]        o_state;

  int errors = 0;
  int checks = 0;

  logic       fixed_mode;
  logic [7:0] fixed_val;

  tx_fir_sequencer #(.NB_OUTPUT(8), .NB_DIV(8), .NBAUDS(6)) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_div       (i_div),
    .i_fir_sample(i_fir_sample),
    .i_ready     (i_ready),
    .o_phase     (o_phase),
    .o_shift     (o_shift),
    .o_fir_enable(o_fir_enable),
    .o_sample    (o_sample),
    .o_valid     (o_valid),
    .o_overrun   (o_overrun),
    .o_state     (o_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // FIR stand-in: a distinct value per phase so the captured phase is visible.
  function automatic logic [7:0] fir_of(input logic [1:0] p);
    return {p, 6'h15};
  endfunction

  always_comb begin
    if (fixed_mode) i_fir_sample = fixed_val;
    else            i_fir_sample = fir_of(o_phase);
  end

  typedef struct {
    int         n;
    logic       en;
    logic       rdy;
    logic [1:0] st;
    logic [1:0] ph;
    logic       sh;
    logic       fe;
    logic       vl;
    logic       ov;
    logic [7:0] smp;
  } vec_t;

  vec_t vecs[18];

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [1:0] ph,
                           input logic sh, input logic fe, input logic vl, input logic ov,
                           input logic [7:0] smp);
    check({tag, ".state"},   32'(o_state), 32'(st));
    check({tag, ".phase"},   32'(o_phase), 32'(ph));
    check({tag, ".shift"},   32'(o_shift), 32'(sh));
    check({tag, ".fir_en"},  32'(o_fir_enable), 32'(fe));
    check({tag, ".valid"},   32'(o_valid), 32'(vl));
    check({tag, ".overrun"}, 32'(o_overrun), 32'(ov));
    check({tag, ".sample"},  32'($unsigned(o_sample)), 32'(smp));
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    i_enable = 1'b0;
    run(2);
    i_reset  = 1'b0;
  endtask

  initial begin
    int s1, s2, cnt, found, c0;
    logic [1:0] p0;

    i_reset    = 1'b1;
    i_enable   = 1'b0;
    i_div      = 8'd0;
    i_ready    = 1'b1;
    fixed_mode = 1'b0;
    fixed_val  = 8'h00;

    //          n   en rdy st    ph    sh fe vl ov smp
    vecs[0]  = '{1,  1, 1, 2'd1, 2'd0, 0, 1, 0, 0, 8'h00};
    vecs[1]  = '{1,  1, 1, 2'd1, 2'd1, 1, 1, 0, 0, 8'h00};
    vecs[2]  = '{1,  1, 1, 2'd1, 2'd2, 0, 1, 0, 0, 8'h00};
    vecs[3]  = '{18, 1, 1, 2'd1, 2'd0, 0, 1, 0, 0, 8'h00};
    vecs[4]  = '{1,  1, 1, 2'd1, 2'd1, 1, 1, 0, 0, 8'h00};
    vecs[5]  = '{1,  1, 1, 2'd2, 2'd2, 0, 1, 0, 0, 8'h00};
    vecs[6]  = '{1,  1, 1, 2'd2, 2'd3, 0, 1, 1, 0, 8'h95};
    vecs[7]  = '{1,  1, 1, 2'd2, 2'd0, 0, 1, 1, 0, 8'hD5};
    vecs[8]  = '{1,  1, 1, 2'd2, 2'd1, 1, 1, 1, 0, 8'h15};
    vecs[9]  = '{1,  1, 1, 2'd2, 2'd2, 0, 1, 1, 0, 8'h55};
    vecs[10] = '{1,  1, 0, 2'd2, 2'd3, 0, 1, 1, 1, 8'h55};
    vecs[11] = '{1,  1, 1, 2'd2, 2'd0, 0, 1, 1, 1, 8'hD5};
    vecs[12] = '{1,  1, 1, 2'd2, 2'd1, 1, 1, 1, 1, 8'h15};
    vecs[13] = '{1,  0, 1, 2'd3, 2'd2, 0, 1, 1, 1, 8'h55};
    vecs[14] = '{1,  0, 1, 2'd3, 2'd3, 0, 1, 1, 1, 8'h95};
    vecs[15] = '{1,  0, 1, 2'd0, 2'd0, 0, 0, 1, 1, 8'hD5};
    vecs[16] = '{1,  0, 0, 2'd0, 2'd0, 0, 0, 1, 1, 8'hD5};
    vecs[17] = '{1,  0, 1, 2'd0, 2'd0, 0, 0, 0, 1, 8'hD5};

    run(2);
    i_reset = 1'b0;
    check_all("reset", 2'd0, 2'd0, 0, 0, 0, 0, 8'h00);

    // Full div=0 run: 23 clocks of priming, first capture on the 24th edge.
    for (int i = 0; i < 18; i++) begin
      i_enable = vecs[i].en;
      i_ready  = vecs[i].rdy;
      run(vecs[i].n);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ph, vecs[i].sh,
                vecs[i].fe, vecs[i].vl, vecs[i].ov, vecs[i].smp);
    end

    // Disable during PRIME returns straight to IDLE without captures.
    do_reset();
    i_div = 8'd0;
    i_enable = 1'b1;
    run(3);
    check("abort.in_prime", 32'(o_state), 32'd1);
    i_enable = 1'b0;
    run(1);
    check_all("abort", 2'd0, 2'd0, 0, 0, 0, 0, 8'h00);

    // div=3: shift every 16 clocks, first shift 8 clocks after start.
    do_reset();
    i_div = 8'd3;
    i_ready = 1'b1;
    i_enable = 1'b1;
    s1 = -1; s2 = -1; cnt = 0;
    for (int k = 0; k < 200 && s2 < 0; k++) begin
      run(1);
      cnt++;
      if (o_shift) begin
        if (s1 < 0) s1 = cnt;
        else        s2 = cnt;
      end
    end
    check("div3.first_shift", 32'(s1), 32'd8);
    check("div3.shift_period", 32'(s2 - s1), 32'd16);

    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      run(1);
      if (o_state == 2'd2) found = 1;
    end
    check("div3.reach_run", 32'(found), 32'd1);
    i_div = 8'd0;
    found = 0;
    p0 = o_phase;
    for (int k = 0; k < 10 && found == 0; k++) begin
      run(1);
      if (o_phase != p0) found = 1;
    end
    p0 = o_phase;
    c0 = 0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      run(1);
      c0++;
      if (o_phase != p0) found = 1;
    end
    check("div3.tick_period_after_div_change", 32'(c0), 32'd4);
    check("div3.no_overrun", 32'(o_overrun), 32'd0);

    // Hold i_ready low across two ticks: first held, second dropped.
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      run(1);
      if (!o_valid) found = 1;
    end
    check("ovr.valid_cleared", 32'(found), 32'd1);
    fixed_mode = 1'b1;
    fixed_val  = 8'h5A;
    i_ready    = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      run(1);
      if (o_valid) found = 1;
    end
    check("ovr.first_capture", 32'(found), 32'd1);
    check("ovr.first_sample", 32'($unsigned(o_sample)), 32'h5A);
    check("ovr.no_overrun_yet", 32'(o_overrun), 32'd0);
    fixed_val = 8'h33;
    run(4);
    check("ovr.held_valid", 32'(o_valid), 32'd1);
    check("ovr.held_sample", 32'($unsigned(o_sample)), 32'h5A);
    check("ovr.overrun_set", 32'(o_overrun), 32'd1);
    i_ready   = 1'b1;
    fixed_val = 8'h44;
    run(1);
    check("ovr.consumed", 32'(o_valid), 32'd0);
    check("ovr.sticky", 32'(o_overrun), 32'd1);
    run(3);
    check("ovr.next_valid", 32'(o_valid), 32'd1);
    check("ovr.next_sample", 32'($unsigned(o_sample)), 32'h44);
    check("ovr.still_sticky", 32'(o_overrun), 32'd1);

    // Reset mid-run with a pending sample, then a full re-prime.
    i_reset  = 1'b1;
    i_enable = 1'b0;
    run(1);
    check_all("midreset", 2'd0, 2'd0, 0, 0, 0, 0, 8'h00);
    i_reset    = 1'b0;
    fixed_mode = 1'b0;
    i_div      = 8'd0;
    i_enable   = 1'b1;
    run(22);
    check("restart.still_prime", 32'(o_state), 32'd1);
    run(1);
    check("restart.run", 32'(o_state), 32'd2);
    check("restart.no_valid", 32'(o_valid), 32'd0);
    run(1);
    check("restart.first_valid", 32'(o_valid), 32'd1);
    check("restart.first_sample", 32'($unsigned(o_sample)), 32'h95);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
